regfile_scoreboard: RTL and testbench

Parametrised integer register file for the single-cycle/multi-cycle RISC-V datapath: XLEN-wide registers, NREGS entries, NUM_RD combinational read ports and one write port.
- Register 0 is hardwired to zero.
- Optional write-to-read bypass.
- A per-register busy scoreboard lets multi-cycle units reserve a destination; reads of a pending register are flagged busy so the controller can stall.
- Debug snapshot of all registers for board-level display.

---
 rtl/rv_regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard_busy.sv | 76 +++++++
 rtl/regfile_scoreboard.sv | 109 ++++++++++
 tb/tb_regfile_scoreboard.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_regfile_pkg.sv
// Shared definitions for the integer register file and the instruction decoder.
//
// Contents:
//   ZERO_REG   - index of the hardwired-zero register (x0)
//   DEF_XLEN   - default register width in bits
//   DEF_NREGS  - default number of architectural registers
//   reg_addr_t - register index type sized for DEF_NREGS
//   reg_data_t - register value type sized for DEF_XLEN
package rv_regfile_pkg;

  localparam int unsigned ZERO_REG  = 0;
  localparam int unsigned DEF_XLEN  = 8;
  localparam int unsigned DEF_NREGS = 8;

  typedef logic [$clog2(DEF_NREGS)-1:0] reg_addr_t;
  typedef logic [DEF_XLEN-1:0]          reg_data_t;

endpackage : rv_regfile_pkg

// File: rtl/regfile_scoreboard_busy.sv
// Busy-bit scoreboard for the register file.
//
// One busy bit per register marks a destination reserved by a multi-cycle unit.
// A reservation is refused while the register is still busy, unless that same
// register is being written back in this cycle. A writeback clears the busy bit.
// A reservation on the same edge sets it again, so the reservation takes
// priority. Register 0 never becomes busy.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (clears every busy bit)
//   wr_en_i      writeback strobe
//   wr_addr_i    writeback destination
//   rsv_en_i     reservation request
//   rsv_addr_i   register to reserve
//   rsv_grant_o  reservation accepted this cycle (combinational)
//   busy_o       busy bit vector, one bit per register
//   busy_count_o number of busy registers (combinational popcount)
module regfile_scoreboard_busy
  import rv_regfile_pkg::*;
#(
  parameter  int unsigned NREGS = DEF_NREGS,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic            rsv_en_i,
  input  logic [AW-1:0]   rsv_addr_i,
  output logic            rsv_grant_o,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]     busy_count_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             rsv_is_zero;
  logic             wb_hits_rsv;

  assign rsv_is_zero = (rsv_addr_i == AW'(ZERO_REG));
  assign wb_hits_rsv = wr_en_i && (wr_addr_i == rsv_addr_i);

  // A busy register may be re-reserved only when its writeback lands in the
  // same cycle, so the old and new producers never overlap.
  assign rsv_grant_o = rsv_en_i && (rsv_is_zero || !busy_q[rsv_addr_i] || wb_hits_rsv);

  always_comb begin
    busy_d = busy_q;
    if (wr_en_i) begin
      busy_d[wr_addr_i] = 1'b0;
    end
    // Applied after the writeback clear so a simultaneous reservation wins.
    if (rsv_grant_o && !rsv_is_zero) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_count_o = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_count_o = busy_count_o + (AW + 1)'(busy_q[i]);
    end
  end

  assign busy_o = busy_q;

endmodule : regfile_scoreboard_busy

// File: rtl/regfile_scoreboard.sv
// Integer register file with a busy scoreboard for the RISC-V datapath.
//
// NREGS registers of XLEN bits, NUM_RD combinational read ports and one
// write port. Register 0 always reads zero and ignores writes. With BYPASS
// set, a read of the register being written in the same cycle returns the
// incoming write data and is not reported busy, because that write is the
// writeback that retires the reservation.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   wr_en         write/writeback strobe
//   wr_addr       write destination
//   wr_data       write data
//   rd_addr       read addresses, one per read port
//   rd_data       read data, one per read port (combinational)
//   rd_busy       per read port: addressed register has a pending reservation
//   rsv_en        request to reserve a destination register
//   rsv_addr      register to reserve
//   rsv_grant     reservation accepted this cycle
//   busy_count    number of registers currently busy
//   debug_reg_out live register contents for board-level display
module regfile_scoreboard
  import rv_regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = DEF_XLEN,
  parameter  int unsigned NREGS  = DEF_NREGS,
  parameter  int unsigned NUM_RD = 2,
  parameter  bit          BYPASS = 1'b1,
  localparam int unsigned AW     = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [XLEN-1:0]    wr_data,
  input  logic [AW-1:0]      rd_addr       [NUM_RD],
  output logic [XLEN-1:0]    rd_data       [NUM_RD],
  output logic [NUM_RD-1:0]  rd_busy,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic               rsv_grant,
  output logic [AW:0]        busy_count,
  output logic [XLEN-1:0]    debug_reg_out [NREGS]
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_live;

  // Writes to x0 are dropped here so regs_q[0] stays zero from reset onwards.
  assign wr_live = wr_en && (wr_addr != AW'(ZERO_REG));

  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard_busy #(
    .NREGS (NREGS)
  ) u_busy (
    .clk_i        (clk),
    .rst_ni       (rst),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .rsv_en_i     (rsv_en),
    .rsv_addr_i   (rsv_addr),
    .rsv_grant_o  (rsv_grant),
    .busy_o       (busy),
    .busy_count_o (busy_count)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (rd_addr[i] == AW'(ZERO_REG)) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end else if (BYPASS && wr_en && (wr_addr == rd_addr[i])) begin
        rd_data[i] = wr_data;
        rd_busy[i] = 1'b0;
      end else begin
        rd_data[i] = regs_q[rd_addr[i]];
        rd_busy[i] = busy[rd_addr[i]];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      debug_reg_out[i] = regs_q[i];
    end
  end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int NREGS = 8;
  localparam int NRD   = 2;

  typedef struct packed {
    logic [15:0] rd_a;    // two ports of the BYPASS=1 instance
    logic [15:0] rd_b;    // two ports of the BYPASS=0 instance
    logic [1:0]  busy_a;
    logic [1:0]  busy_b;
    logic        grant;
    logic [3:0]  cnt;
    logic [63:0] dbg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [2:0] rd_addr [NRD];
  logic       rsv_en = 1'b0;
  logic [2:0] rsv_addr = '0;

  logic [7:0] rd_data_a [NRD];
  logic [7:0] rd_data_b [NRD];
  logic [1:0] rd_busy_a, rd_busy_b;
  logic       grant_a, grant_b;
  logic [3:0] cnt_a, cnt_b;
  logic [7:0] dbg_a [NREGS];
  logic [7:0] dbg_b [NREGS];

  int total = 0;
  int bad   = 0;
  exp_t expq[$];

  // Reference state: architectural register values and pending reservations.
  logic [7:0] m_regs [NREGS];
  bit         m_busy [NREGS];

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .XLEN (8), .NREGS (NREGS), .NUM_RD (NRD), .BYPASS (1'b1)
  ) dut_a (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .rd_addr (rd_addr), .rd_data (rd_data_a), .rd_busy (rd_busy_a),
    .rsv_en (rsv_en), .rsv_addr (rsv_addr), .rsv_grant (grant_a),
    .busy_count (cnt_a), .debug_reg_out (dbg_a)
  );

  regfile_scoreboard #(
    .XLEN (8), .NREGS (NREGS), .NUM_RD (NRD), .BYPASS (1'b0)
  ) dut_b (
    .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
    .rd_addr (rd_addr), .rd_data (rd_data_b), .rd_busy (rd_busy_b),
    .rsv_en (rsv_en), .rsv_addr (rsv_addr), .rsv_grant (grant_b),
    .busy_count (cnt_b), .debug_reg_out (dbg_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, queue what the outputs must be before the
  // next edge, then advance the reference state across that edge.
  task automatic cyc(input bit r, input bit we, input int wa, input int wd,
                     input int ra0, input int ra1, input bit re, input int rsa);
    exp_t e;
    logic [2:0] a, w, s;
    bit g;
    int n;
    w = 3'(wa);
    s = 3'(rsa);
    rst = r; wr_en = we; wr_addr = w; wr_data = 8'(wd);
    rd_addr[0] = 3'(ra0); rd_addr[1] = 3'(ra1);
    rsv_en = re; rsv_addr = s;
    if (!r) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 0;
      end
    end
    e = '0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p];
      if (a != 0) begin
        e.rd_b[p*8 +: 8] = m_regs[a];
        e.busy_b[p]      = m_busy[a];
        if (we && w == a) begin
          e.rd_a[p*8 +: 8] = 8'(wd);
          e.busy_a[p]      = 1'b0;
        end else begin
          e.rd_a[p*8 +: 8] = m_regs[a];
          e.busy_a[p]      = m_busy[a];
        end
      end
    end
    g = re && (s == 0 || !m_busy[s] || (we && w == s));
    e.grant = g;
    n = 0;
    for (int i = 0; i < NREGS; i++) begin
      n += int'(m_busy[i]);
      e.dbg[i*8 +: 8] = m_regs[i];
    end
    e.cnt = 4'(n);
    expq.push_back(e);
    if (r) begin
      if (we && w != 0) m_regs[w] = 8'(wd);
      if (we) m_busy[w] = 0;
      if (g && s != 0) m_busy[s] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      logic [63:0] da, db;
      e = expq.pop_front();
      for (int i = 0; i < NREGS; i++) begin
        da[i*8 +: 8] = dbg_a[i];
        db[i*8 +: 8] = dbg_b[i];
      end
      chk("rd_data0_byp", 64'(rd_data_a[0]), 64'(e.rd_a[7:0]));
      chk("rd_data1_byp", 64'(rd_data_a[1]), 64'(e.rd_a[15:8]));
      chk("rd_data0_nobyp", 64'(rd_data_b[0]), 64'(e.rd_b[7:0]));
      chk("rd_data1_nobyp", 64'(rd_data_b[1]), 64'(e.rd_b[15:8]));
      chk("rd_busy_byp", 64'(rd_busy_a), 64'(e.busy_a));
      chk("rd_busy_nobyp", 64'(rd_busy_b), 64'(e.busy_b));
      chk("rsv_grant_byp", 64'(grant_a), 64'(e.grant));
      chk("rsv_grant_nobyp", 64'(grant_b), 64'(e.grant));
      chk("busy_count_byp", 64'(cnt_a), 64'(e.cnt));
      chk("busy_count_nobyp", 64'(cnt_b), 64'(e.cnt));
      chk("debug_regs_byp", da, e.dbg);
      chk("debug_regs_nobyp", db, e.dbg);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wa, rsa;
    rd_addr[0] = '0;
    rd_addr[1] = '0;
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    @(posedge clk);
    #1;
    // Reset held, then released; read every address on both ports.
    cyc(0, 0, 0, 0, 0, 7, 0, 0);
    cyc(0, 1, 3, 8'h99, 3, 4, 1, 2);
    for (int i = 0; i < NREGS; i += 2) cyc(1, 0, 0, 0, i, i + 1, 0, 0);
    // Write r3, then a discarded write to r0.
    cyc(1, 1, 3, 8'hA5, 0, 0, 0, 0);
    cyc(1, 1, 0, 8'hFF, 3, 0, 0, 0);
    cyc(1, 0, 0, 0, 3, 0, 0, 0);
    // Same-cycle write and read of r5.
    cyc(1, 1, 5, 8'h3C, 5, 5, 0, 0);
    cyc(1, 0, 0, 0, 5, 5, 0, 0);
    // Reserve r2, refused second reservation, writeback clears it.
    cyc(1, 0, 0, 0, 2, 2, 1, 2);
    cyc(1, 0, 0, 0, 2, 3, 1, 2);
    cyc(1, 1, 2, 8'h11, 2, 2, 0, 0);
    cyc(1, 0, 0, 0, 2, 0, 0, 0);
    // r4 busy, then writeback and re-reservation in the same cycle.
    cyc(1, 0, 0, 0, 4, 0, 1, 4);
    cyc(1, 1, 4, 8'h77, 4, 4, 1, 4);
    cyc(1, 0, 0, 0, 4, 4, 0, 0);
    // Reserving r0 is always granted and changes nothing.
    cyc(1, 0, 0, 0, 0, 4, 1, 0);
    // Reserve r1 and r6, then reset between edges.
    cyc(1, 0, 0, 0, 1, 6, 1, 1);
    cyc(1, 1, 3, 8'h5A, 1, 6, 1, 6);
    cyc(1, 0, 0, 0, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 1, 6, 1, 1);
    cyc(1, 0, 0, 0, 3, 6, 0, 0);
    // Randomized traffic with a narrowed address range for more conflicts.
    for (int k = 0; k < 600; k++) begin
      wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
      rsa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1, wa, int'($urandom_range(0, 255)),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          $urandom_range(0, 1) == 1, rsa);
    end
    @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
